// File: rtl/exec_ctrl.sv
// exec_ctrl: run/step/breakpoint execution controller issuing a one-clk instruction-advance strobe to the SoC.
// Step button is synchronized and debounced; instr_count tallies every strobe issued.
module exec_ctrl #(
    parameter int unsigned SLOW_DIV  = 12_500_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        turbo_mode,
    input  logic        step,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  ip,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        halted,
    output logic [15:0] instr_count
);
    localparam int DW  = $clog2(SLOW_DIV);
    localparam int DBW = $clog2(DB_CYCLES);
    localparam logic [DW-1:0]  DIV_MAX = DW'(SLOW_DIV - 1);
    localparam logic [DBW-1:0] DB_MAX  = DBW'(DB_CYCLES - 1);
    typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, BRK = 2'b11} state_t;
    logic [1:0]     sync_q, vld_q;
    logic           db_q, db_prev_q, arm_q;
    logic [DBW-1:0] dbc_q;
    state_t         state_q, state_d;
    logic           cpu_en_q, cpu_en_d, halted_q, first_q, first_d;
    logic [DW-1:0]  div_q, div_d, div_nx;
    logic [15:0]    cnt_q;
    logic [7:0]     ip_nx;
    logic           step_pulse, tick, bp_hit;
    // arm_q blocks a press that was already held through reset until the button is seen released
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= '0;
            vld_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            dbc_q     <= '0;
            arm_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], step};
            vld_q     <= {vld_q[0], 1'b1};
            db_prev_q <= db_q;
            if (sync_q[1] != db_q) begin
                db_q  <= (dbc_q == DB_MAX) ? sync_q[1] : db_q;
                dbc_q <= (dbc_q == DB_MAX) ? '0 : dbc_q + DBW'(1);
            end else begin
                dbc_q <= '0;
            end
            if (vld_q[1] && !sync_q[1]) arm_q <= 1'b1;
        end
    end
    assign step_pulse = db_q & ~db_prev_q & arm_q;
    assign div_nx     = (turbo_mode || div_q == DIV_MAX) ? '0 : div_q + DW'(1);
    assign tick       = turbo_mode || div_nx == DIV_MAX;
    // the strobe is registered, so the address it will execute is ip advanced by any strobe still in flight
    assign ip_nx      = ip + {7'b0, cpu_en_q};
    assign bp_hit     = bp_en && ip_nx == bp_addr;
    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        first_d  = first_q;
        cpu_en_d = 1'b0;
        case (state_q)
            HALT: begin
                if (run) begin
                    state_d  = RUN;
                    cpu_en_d = turbo_mode;
                    first_d  = ~turbo_mode;
                end else if (step_pulse) begin
                    state_d  = STEP;
                    cpu_en_d = 1'b1;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = HALT;
                end else begin
                    div_d = div_nx;
                    if (tick && !first_q && bp_hit) begin
                        state_d = BRK;
                    end else if (tick) begin
                        cpu_en_d = 1'b1;
                        first_d  = 1'b0;
                    end
                end
            end
            STEP: state_d = HALT;
            BRK: begin
                if (!run) begin
                    state_d = HALT;
                end else if (step_pulse) begin
                    state_d  = STEP;
                    cpu_en_d = 1'b1;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= HALT;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b1;
            cnt_q    <= '0;
            div_q    <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            halted_q <= state_d != RUN;
            cnt_q    <= cnt_q + {15'b0, cpu_en_d};
            div_q    <= div_d;
            first_q  <= first_d;
        end
    end
    assign cpu_en      = cpu_en_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed checks of exec_ctrl with SLOW_DIV=4, DB_CYCLES=3.
module tb_exec_ctrl;
    logic        clk = 1'b0, resetn = 1'b0, run = 1'b0, turbo_mode = 1'b0, step = 1'b0;
    logic        bp_en = 1'b0, ip_clr = 1'b1;
    logic [7:0]  bp_addr = 8'h00, ip = 8'h00;
    logic        cpu_en, halted;
    logic [1:0]  state;
    logic [15:0] instr_count;
    int          tests = 0, fails = 0, pulses = 0;
    bit          saw_step = 1'b0;

    always #5 clk = ~clk;

    // SoC model: each strobe advances the instruction pointer by one
    always @(posedge clk) ip <= ip_clr ? 8'h00 : ip + {7'b0, cpu_en};

    exec_ctrl #(.SLOW_DIV(4), .DB_CYCLES(3)) dut (
        .clk(clk), .resetn(resetn), .run(run), .turbo_mode(turbo_mode), .step(step),
        .bp_en(bp_en), .bp_addr(bp_addr), .ip(ip), .cpu_en(cpu_en), .state(state),
        .halted(halted), .instr_count(instr_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_state", state, 0);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_halted", halted, 1);
        chk("rst_count", instr_count, 0);
        resetn = 1'b1;
        ip_clr = 1'b0;
        repeat (3) cyc();
        // slow run: strobe on RUN clks 4, 8, 12
        run = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk($sformatf("slow_en_%0d", i), cpu_en, (i % 4 == 0));
        end
        chk("slow_state", state, 1);
        chk("slow_halted", halted, 0);
        chk("slow_count", instr_count, 3);
        run = 1'b0;
        cyc();
        chk("slow_stop_state", state, 0);
        chk("slow_stop_en", cpu_en, 0);
        chk("slow_stop_halted", halted, 1);
        // turbo run: five clks of run, five strobes
        turbo_mode = 1'b1;
        run = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk($sformatf("turbo_en_%0d", i), cpu_en, 1);
        end
        run = 1'b0;
        cyc();
        chk("turbo_stop_en", cpu_en, 0);
        chk("turbo_stop_state", state, 0);
        chk("turbo_stop_halted", halted, 1);
        chk("turbo_count", instr_count, 8);
        // bouncy step press
        turbo_mode = 1'b0;
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        step = 1'b1;
        pulses = 0;
        saw_step = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            pulses += int'(cpu_en);
            if (state == 2'b10) saw_step = 1'b1;
        end
        chk("step_pulses", pulses, 1);
        chk("step_seen", saw_step, 1);
        chk("step_end_state", state, 0);
        chk("step_count", instr_count, 9);
        step = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            pulses += int'(cpu_en);
        end
        chk("step_release_pulses", pulses, 0);
        // breakpoint at 0x05 during turbo run, then resume
        ip_clr = 1'b1;
        cyc();
        ip_clr = 1'b0;
        bp_en = 1'b1;
        bp_addr = 8'h05;
        turbo_mode = 1'b1;
        run = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20 && state != 2'b11; i++) begin
            cyc();
            pulses += int'(cpu_en);
        end
        chk("bp_state", state, 3);
        chk("bp_cpu_en", cpu_en, 0);
        chk("bp_ip", ip, 8'h05);
        chk("bp_pulses", pulses, 5);
        chk("bp_halted", halted, 1);
        repeat (3) cyc();
        chk("bp_hold_state", state, 3);
        chk("bp_hold_ip", ip, 8'h05);
        run = 1'b0;
        cyc();
        chk("bp_exit_state", state, 0);
        run = 1'b1;
        cyc();
        chk("resume_en", cpu_en, 1);
        chk("resume_ip", ip, 8'h05);
        run = 1'b0;
        cyc();
        chk("resume_stop_state", state, 0);
        chk("resume_ip_next", ip, 8'h06);
        chk("resume_count", instr_count, 15);
        // asynchronous reset mid turbo run, with step held through it
        bp_en = 1'b0;
        run = 1'b1;
        repeat (3) cyc();
        chk("pre_rst_en", cpu_en, 1);
        #2;
        resetn = 1'b0;
        step = 1'b1;
        #1;
        chk("async_rst_en", cpu_en, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_halted", halted, 1);
        chk("async_rst_count", instr_count, 0);
        run = 1'b0;
        repeat (2) cyc();
        chk("rst_hold_en", cpu_en, 0);
        chk("rst_hold_count", instr_count, 0);
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            pulses += int'(cpu_en);
        end
        chk("held_step_pulses", pulses, 0);
        chk("held_step_state", state, 0);
        step = 1'b0;
        repeat (10) cyc();
        step = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            pulses += int'(cpu_en);
        end
        chk("repress_pulses", pulses, 1);
        chk("repress_count", instr_count, 1);
        step = 1'b0;
        repeat (10) cyc();
        // counter wrap
        turbo_mode = 1'b1;
        run = 1'b1;
        repeat (65534) cyc();
        chk("wrap_pre_count", instr_count, 16'hFFFF);
        cyc();
        chk("wrap_en", cpu_en, 1);
        chk("wrap_count", instr_count, 16'h0000);
        run = 1'b0;
        cyc();
        chk("wrap_stop_state", state, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
